// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: control inputs and tick outputs of the fractional baud generator.
interface uart_baud_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OVS    = 16
);
    logic                    i_en;
    logic                    i_sync;
    logic                    i_div_wr;
    logic [DIV_W-1:0]        i_div_int;
    logic [FRAC_W-1:0]       i_div_frac;
    logic                    o_div_pending;
    logic                    o_ovs_tick;
    logic                    o_bit_tick;
    logic                    o_mid_tick;
    logic [$clog2(OVS)-1:0]  o_ovs_idx;

    modport master (
        output i_en, i_sync, i_div_wr, i_div_int, i_div_frac,
        input  o_div_pending, o_ovs_tick, o_bit_tick, o_mid_tick, o_ovs_idx
    );

    modport slave (
        input  i_en, i_sync, i_div_wr, i_div_int, i_div_frac,
        output o_div_pending, o_ovs_tick, o_bit_tick, o_mid_tick, o_ovs_idx
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional oversample/bit/mid-bit tick generator with staged divisor updates.
module uart_baud_gen #(
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4,
    parameter int OVS      = 16,
    parameter int DEF_DIV  = 27,
    parameter int DEF_FRAC = 2
) (
    input logic            i_clk,
    input logic            i_rst,
    uart_baud_gen_if.slave bus
);
    localparam int IW = $clog2(OVS);
    localparam int CW = DIV_W + 1;

    logic [DIV_W-1:0]  div_int_q, div_int_d, stg_int_q, stg_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d, stg_frac_q, stg_frac_d, acc_q, acc_d;
    logic              carry_q, carry_d, pend_q, pend_d;
    logic [CW-1:0]     cnt_q, cnt_d, len;
    logic [IW-1:0]     idx_q, idx_d;
    logic              ovs_q, ovs_d, bit_q, bit_d, mid_q, mid_d;
    logic              run, tick, bit_evt, apply, clr_acc;

    // sync and disable both restart the phase and double as divisor apply points
    always_comb begin
        len        = (div_int_q < DIV_W'(2) ? CW'(2) : CW'(div_int_q)) + CW'(carry_q);
        run        = bus.i_en && !bus.i_sync;
        tick       = run && cnt_q == len - CW'(1);
        bit_evt    = tick && idx_q == IW'(OVS - 1);
        apply      = !run || bit_evt;
        clr_acc    = !run || (bit_evt && pend_q);
        cnt_d      = (run && !tick) ? cnt_q + CW'(1) : '0;
        idx_d      = run ? idx_q + IW'(tick) : '0;
        {carry_d, acc_d} = clr_acc ? '0
                         : tick ? {1'b0, acc_q} + {1'b0, div_frac_q}
                         : {carry_q, acc_q};
        ovs_d      = tick;
        bit_d      = bit_evt;
        mid_d      = tick && idx_q == IW'(OVS / 2 - 1);
        div_int_d  = apply ? stg_int_q : div_int_q;
        div_frac_d = apply ? stg_frac_q : div_frac_q;
        stg_int_d  = bus.i_div_wr ? bus.i_div_int : stg_int_q;
        stg_frac_d = bus.i_div_wr ? bus.i_div_frac : stg_frac_q;
        pend_d     = bus.i_div_wr || (pend_q && !apply);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_int_q  <= DIV_W'(DEF_DIV);
            div_frac_q <= FRAC_W'(DEF_FRAC);
            stg_int_q  <= DIV_W'(DEF_DIV);
            stg_frac_q <= FRAC_W'(DEF_FRAC);
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            ovs_q      <= 1'b0;
            bit_q      <= 1'b0;
            mid_q      <= 1'b0;
        end else begin
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            stg_int_q  <= stg_int_d;
            stg_frac_q <= stg_frac_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            ovs_q      <= ovs_d;
            bit_q      <= bit_d;
            mid_q      <= mid_d;
        end
    end

    assign bus.o_div_pending = pend_q;
    assign bus.o_ovs_tick    = ovs_q;
    assign bus.o_bit_tick    = bit_q;
    assign bus.o_mid_tick    = mid_q;
    assign bus.o_ovs_idx     = idx_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: closed-form tick-time model checked every cycle, plus literal timing pins.
module tb_uart_baud_gen;
    localparam int DIV_W = 16, FRAC_W = 4, OVS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_pass = 0;

    uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) bus ();

    uart_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .DEF_DIV(27), .DEF_FRAC(2)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int deff(input int d);
        return d < 2 ? 2 : d;
    endfunction

    // Model: after a phase restart at edge seg with divisor D+F/16, tick n lands on
    // edge seg + n*D + floor((n-1)*F/16); kc counts ticks since the last restart.
    int   edge_n = 0, seg = 0, nxt = 1, kc = 0;
    int   m_d = 27, m_f = 2, s_d = 27, s_f = 2;
    bit   m_pend = 0, m_apply = 0, mvalid = 0, e_ovs = 0, e_bit = 0, e_mid = 0;
    logic [1:0] e_idx = '0;

    always @(posedge clk) begin
        edge_n++;
        e_ovs = 0; e_bit = 0; e_mid = 0; m_apply = 0;
        if (rst) begin
            m_d = 27; m_f = 2; s_d = 27; s_f = 2; m_pend = 0;
            seg = edge_n; nxt = 1; kc = 0; mvalid = 1;
        end else begin
            if (bus.i_sync || !bus.i_en) begin
                m_apply = 1; seg = edge_n; nxt = 1; kc = 0;
            end else if (edge_n == seg + nxt * deff(m_d) + ((nxt - 1) * m_f) / 16) begin
                e_ovs = 1; kc++; nxt++;
                e_bit = (kc % OVS) == 0;
                e_mid = (kc % OVS) == OVS / 2;
                if (e_bit && m_pend) begin
                    m_apply = 1; seg = edge_n; nxt = 1;
                end
            end
            if (m_apply) begin
                m_d = s_d; m_f = s_f; m_pend = 0;
            end
            if (bus.i_div_wr) begin
                s_d = int'(bus.i_div_int); s_f = int'(bus.i_div_frac); m_pend = 1;
            end
        end
        e_idx = 2'(kc % OVS);
    end

    always @(negedge clk) begin
        if (mvalid)
            chk("cycle_outputs",
                int'({bus.o_div_pending, bus.o_ovs_tick, bus.o_bit_tick, bus.o_mid_tick, bus.o_ovs_idx}),
                int'({m_pend, e_ovs, e_bit, e_mid, e_idx}));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit sig(input int w);
        case (w)
            0: return bus.o_ovs_tick;
            1: return bus.o_bit_tick;
            2: return bus.o_mid_tick;
            3: return !bus.o_div_pending;
            4: return bus.o_ovs_tick && bus.o_ovs_idx == 2'd1;
            5: return bus.o_ovs_tick && bus.o_ovs_idx == 2'd3;
            default: return bus.o_ovs_tick && bus.o_ovs_idx == 2'd2;
        endcase
    endfunction

    task automatic wait_for(input int w, output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (sig(w)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic write_div(input int d, input int f);
        bus.i_div_wr = 1'b1;
        bus.i_div_int = DIV_W'(d);
        bus.i_div_frac = FRAC_W'(f);
        step();
        bus.i_div_wr = 1'b0;
    endtask

    int n, total, any_tick, any_idx;

    initial begin
        bus.i_en = 1'b0; bus.i_sync = 1'b0; bus.i_div_wr = 1'b0;
        bus.i_div_int = '0; bus.i_div_frac = '0;
        step(); step();
        chk("reset_outputs", int'({bus.o_div_pending, bus.o_ovs_tick, bus.o_bit_tick,
                                   bus.o_mid_tick, bus.o_ovs_idx}), 0);
        rst = 1'b0;

        // divisor 4/0, applied by the disabled cycle that follows the write
        write_div(4, 0);
        chk("pend_after_write", int'(bus.o_div_pending), 1);
        step();
        chk("pend_applied_disabled", int'(bus.o_div_pending), 0);
        bus.i_en = 1'b1;
        wait_for(0, n); chk("first_ovs_tick", n, 4);
        chk("first_idx", int'(bus.o_ovs_idx), 1);
        wait_for(1, n); chk("first_bit_tick", n, 12);
        wait_for(2, n); chk("bit_to_mid", n, 8);
        wait_for(1, n); chk("mid_to_bit", n, 8);

        // 4.5 average: 32 ovs periods span 144 cycles
        write_div(4, 8);
        wait_for(3, n); chk("frac_apply", int'(n > 0), 1);
        wait_for(0, n);
        total = 0;
        repeat (32) begin
            wait_for(0, n);
            total += (n < 0) ? 1000 : n;
        end
        chk("frac_32_periods", total, 144);

        // staged change at idx 1 waits for the bit boundary
        write_div(4, 0);
        wait_for(3, n); chk("back_to_4", int'(n > 0), 1);
        wait_for(4, n); chk("reach_idx1", int'(n > 0), 1);
        write_div(6, 0);
        chk("pend_staged", int'(bus.o_div_pending), 1);
        wait_for(1, n); chk("old_div_to_bit", n, 11);
        chk("pend_drop_at_bit", int'(bus.o_div_pending), 0);
        wait_for(0, n); chk("new_period_6", n, 6);

        // sync at cnt=2, idx=3
        write_div(4, 0);
        wait_for(3, n); chk("back_to_4b", int'(n > 0), 1);
        wait_for(5, n); chk("reach_idx3", int'(n > 0), 1);
        step(); step();
        bus.i_sync = 1'b1;
        step();
        bus.i_sync = 1'b0;
        chk("sync_no_tick", int'({bus.o_ovs_tick, bus.o_bit_tick, bus.o_mid_tick, bus.o_ovs_idx}), 0);
        wait_for(0, n); chk("sync_to_tick", n, 4);
        chk("sync_tick_idx", int'(bus.o_ovs_idx), 1);
        total = n;
        wait_for(2, n); chk("sync_to_mid", total + n, 8);

        // clamp, disable, mid-bit reset
        write_div(0, 0);
        wait_for(3, n); chk("clamp_apply", int'(n > 0), 1);
        wait_for(0, n);
        wait_for(0, n); chk("clamp_period", n, 2);
        bus.i_en = 1'b0;
        any_tick = 0; any_idx = 0;
        repeat (10) begin
            step();
            any_tick |= int'(bus.o_ovs_tick | bus.o_bit_tick | bus.o_mid_tick);
            any_idx |= int'(bus.o_ovs_idx);
        end
        chk("disabled_ticks", any_tick, 0);
        chk("disabled_idx", any_idx, 0);
        bus.i_en = 1'b1;
        wait_for(6, n); chk("reach_idx2", int'(n > 0), 1);
        step();
        write_div(9, 0);
        chk("pend_before_rst", int'(bus.o_div_pending), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_reset", int'({bus.o_div_pending, bus.o_ovs_tick, bus.o_bit_tick,
                                  bus.o_mid_tick, bus.o_ovs_idx}), 0);
        wait_for(0, n); chk("default_period1", n, 27);
        wait_for(0, n); chk("default_period2", n, 27);
        repeat (6) wait_for(0, n);
        wait_for(0, n); chk("default_carry_period", n, 28);

        // randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 499) == 0);
            bus.i_sync = ($urandom_range(0, 59) == 0);
            bus.i_en = ($urandom_range(0, 39) != 0);
            bus.i_div_wr = ($urandom_range(0, 29) == 0);
            bus.i_div_int = DIV_W'($urandom_range(0, 7));
            bus.i_div_frac = FRAC_W'($urandom_range(0, 15));
        end
        rst = 1'b0; bus.i_sync = 1'b0; bus.i_div_wr = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
